// File: rtl/io_supply_sequencer_if.sv
// Signal bundle between the housekeeping registers and padframe supply switches
// and the supply sequencer.
interface io_supply_sequencer_if #(
   parameter int NCH  = 4,
   parameter int CNTW = 12
);
   localparam int CHW = $clog2(NCH);

   logic            req_on;
   logic [CNTW-1:0] settle_cycles;
   logic [CNTW-1:0] timeout_cycles;
   logic [NCH-1:0]  pgood;
   logic [NCH-1:0]  en;
   logic            iso_n;
   logic            busy;
   logic            fault;
   logic [CHW-1:0]  fault_ch;

   modport master (
      output req_on, settle_cycles, timeout_cycles, pgood,
      input  en, iso_n, busy, fault, fault_ch
   );

   modport slave (
      input  req_on, settle_cycles, timeout_cycles, pgood,
      output en, iso_n, busy, fault, fault_ch
   );
endinterface

// File: rtl/io_supply_sequencer.sv
// Ordered power-up/power-down sequencer for padframe supply channels.
// Channel 0 powers up first; power-down runs in reverse. Faults are sticky until req_on drops.
module io_supply_sequencer #(
   parameter int NCH  = 4,
   parameter int CNTW = 12
) (
   input logic                  clock,
   input logic                  resetb,
   io_supply_sequencer_if.slave bus
);
   localparam int             CHW      = $clog2(NCH);
   localparam logic [CHW-1:0] LAST_IDX = CHW'(NCH - 1);

   typedef enum logic [2:0] {
      S_OFF, S_RAMP_UP, S_SETTLE_UP, S_ON, S_RAMP_DN, S_FAULT
   } state_e;

   state_e          state_q, state_d;
   logic [CHW-1:0]  idx_q, idx_d;
   logic [CNTW-1:0] cnt_q, cnt_d, cnt_inc;
   logic [CNTW-1:0] settle_q, settle_d;
   logic [CNTW-1:0] timeout_q, timeout_d;
   logic [NCH-1:0]  pg_meta_q, pg_s_q;
   logic [NCH-1:0]  low_up;
   logic [NCH-1:0]  en_q, en_d;
   logic            iso_n_q, iso_n_d;
   logic            busy_q, busy_d;
   logic            fault_q, fault_d;
   logic [CHW-1:0]  fault_ch_q, fault_ch_d;

   function automatic logic [CHW-1:0] lowest_set(input logic [NCH-1:0] v);
      logic [CHW-1:0] r;
      r = '0;
      for (int i = NCH - 1; i >= 0; i--) begin
         if (v[i]) r = CHW'(i);
      end
      return r;
   endfunction

   // NOTE: every variable gets a default at the top, so no path can infer a latch.
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      settle_d   = settle_q;
      timeout_d  = timeout_q;
      fault_ch_d = fault_ch_q;
      cnt_inc    = (cnt_q == '1) ? cnt_q : cnt_q + CNTW'(1);
      cnt_d      = cnt_inc;

      // Channels already powered (0..idx) whose synchronised power-good is low.
      for (int i = 0; i < NCH; i++) begin
         low_up[i] = ~pg_s_q[i] && (i <= int'(idx_q));
      end

      case (state_q)
         S_OFF: begin
            cnt_d = '0;
            if (bus.req_on) begin
               state_d   = S_RAMP_UP;
               idx_d     = '0;
               timeout_d = bus.timeout_cycles;
            end
         end
         S_RAMP_UP: begin
            if (!bus.req_on) begin
               state_d  = S_RAMP_DN;
               cnt_d    = '0;
               settle_d = bus.settle_cycles;
            end else if (pg_s_q[idx_q]) begin
               state_d  = S_SETTLE_UP;
               cnt_d    = '0;
               settle_d = bus.settle_cycles;
            end else if (timeout_q != '0 && cnt_inc == timeout_q) begin
               state_d    = S_FAULT;
               fault_ch_d = idx_q;
            end
         end
         S_SETTLE_UP: begin
            if (|low_up) begin
               state_d    = S_FAULT;
               fault_ch_d = lowest_set(low_up);
            end else if (!bus.req_on) begin
               state_d  = S_RAMP_DN;
               cnt_d    = '0;
               settle_d = bus.settle_cycles;
            end else if (cnt_q == settle_q) begin
               cnt_d = '0;
               if (idx_q == LAST_IDX) begin
                  state_d = S_ON;
               end else begin
                  state_d   = S_RAMP_UP;
                  idx_d     = idx_q + CHW'(1);
                  timeout_d = bus.timeout_cycles;
               end
            end
         end
         S_ON: begin
            cnt_d = '0;
            if (~&pg_s_q) begin
               state_d    = S_FAULT;
               fault_ch_d = lowest_set(~pg_s_q);
            end else if (!bus.req_on) begin
               state_d  = S_RAMP_DN;
               idx_d    = LAST_IDX;
               settle_d = bus.settle_cycles;
            end
         end
         S_RAMP_DN: begin
            if (cnt_q == settle_q) begin
               cnt_d = '0;
               if (idx_q == '0) begin
                  state_d = S_OFF;
               end else begin
                  idx_d    = idx_q - CHW'(1);
                  settle_d = bus.settle_cycles;
               end
            end
         end
         S_FAULT: begin
            cnt_d = '0;
            if (!bus.req_on) state_d = S_OFF;
         end
         default: begin
            state_d = S_OFF;
            cnt_d   = '0;
         end
      endcase

      // Outputs are decoded from the next state so they change on the same edge as the state.
      en_d = '0;
      for (int i = 0; i < NCH; i++) begin
         if (state_d == S_ON)
            en_d[i] = 1'b1;
         else if (state_d == S_RAMP_UP || state_d == S_SETTLE_UP)
            en_d[i] = (i <= int'(idx_d));
         else if (state_d == S_RAMP_DN)
            en_d[i] = (i < int'(idx_d));
      end
      iso_n_d = (state_d == S_ON);
      busy_d  = (state_d == S_RAMP_UP) || (state_d == S_SETTLE_UP) || (state_d == S_RAMP_DN);
      fault_d = (state_d == S_FAULT);
   end

   // NOTE: non-blocking assignments so every flop samples the same pre-edge values;
   // all flops, including the pgood synchroniser, take a defined reset value.
   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) begin
         state_q    <= S_OFF;
         idx_q      <= '0;
         cnt_q      <= '0;
         settle_q   <= '0;
         timeout_q  <= '0;
         pg_meta_q  <= '0;
         pg_s_q     <= '0;
         en_q       <= '0;
         iso_n_q    <= 1'b0;
         busy_q     <= 1'b0;
         fault_q    <= 1'b0;
         fault_ch_q <= '0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         cnt_q      <= cnt_d;
         settle_q   <= settle_d;
         timeout_q  <= timeout_d;
         pg_meta_q  <= bus.pgood;
         pg_s_q     <= pg_meta_q;
         en_q       <= en_d;
         iso_n_q    <= iso_n_d;
         busy_q     <= busy_d;
         fault_q    <= fault_d;
         fault_ch_q <= fault_ch_d;
      end
   end

   assign bus.en       = en_q;
   assign bus.iso_n    = iso_n_q;
   assign bus.busy     = busy_q;
   assign bus.fault    = fault_q;
   assign bus.fault_ch = fault_ch_q;
endmodule
